serial_subtractor: RTL

- Bit-serial N-bit subtractor: computes diff = a - b - bin, one bit per clock, LSB first.
- Core cell is a single-bit full subtractor: difference plus borrow out.
- Borrow chains through one flip-flop, so one cell serves all N bits.
- Sits beside the ripple adders in the arithmetic datapath as a low-area subtract path with a start/done handshake.

---
 rtl/arith_pkg.sv | 18 +
 rtl/full_subtractor.sv | 24 ++
 rtl/serial_subtractor.sv | 129 ++++++++++++
 3 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic datapath types: serial-unit FSM states and counter sizing helper.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int unsigned SERIAL_N_MIN = 2;
  localparam int unsigned SERIAL_N_MAX = 32;

  // Bit count index width; never below one bit so the counter always exists.
  function automatic int unsigned count_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: d = x - y - w, bo = borrow out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic w,
  output logic d,
  output logic bo
);

  logic nx;
  logic xy;
  logic nxy;
  logic t_xy;
  logic t_w;

  xor g_d   (d, x, y, w);
  not g_nx  (nx, x);
  and g_txy (t_xy, nx, y);
  xor g_xy  (xy, x, y);
  not g_nxy (nxy, xy);
  and g_tw  (t_w, nxy, w);
  or  g_bo  (bo, t_xy, t_w);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor (diff = a - b - bin), LSB first, start/done handshake.
// Optional zero/ovf flag outputs when SERIAL_SUB_FLAGS_EN is defined.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         bout
`ifdef SERIAL_SUB_FLAGS_EN
  ,
  output logic         zero,
  output logic         ovf
`endif
);

  localparam int unsigned CW = count_width(N);

  state_t         state;
  state_t         state_nx;
  logic [N-1:0]   a_sh;
  logic [N-1:0]   b_sh;
  logic [N-1:0]   diff_sh;
  logic [N-1:0]   diff_nx;
  logic           borrow;
  logic [CW-1:0]  count;
  logic           cell_d;
  logic           cell_bo;
  logic           last;
  logic           accept;

  full_subtractor u_cell (
    .x  (a_sh[0]),
    .y  (b_sh[0]),
    .w  (borrow),
    .d  (cell_d),
    .bo (cell_bo)
  );

  assign last    = (count == CW'(N - 1));
  assign diff_nx = {cell_d, diff_sh[N-1:1]};
  assign accept  = ready && start;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nx = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        ready    = 1'b1;
        done     = 1'b1;
        state_nx = start ? SHIFT : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh    <= '0;
      b_sh    <= '0;
      diff_sh <= '0;
      borrow  <= 1'b0;
      count   <= '0;
      diff    <= '0;
      bout    <= 1'b0;
    end else if (accept) begin
      a_sh   <= a;
      b_sh   <= b;
      borrow <= bin;
      count  <= '0;
    end else if (state == SHIFT) begin
      diff_sh <= diff_nx;
      a_sh    <= a_sh >> 1;
      b_sh    <= b_sh >> 1;
      borrow  <= cell_bo;
      count   <= count + CW'(1);
      if (last) begin
        diff <= diff_nx;
        bout <= cell_bo;
      end
    end
  end

`ifdef SERIAL_SUB_FLAGS_EN
  logic a_msb;
  logic b_msb;

  // Sign bits are latched at acceptance since operand inputs may change mid-run.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      zero  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      a_msb <= a[N-1];
      b_msb <= b[N-1];
    end else if (state == SHIFT && last) begin
      zero <= (diff_nx == '0);
      ovf  <= (a_msb != b_msb) && (diff_nx[N-1] != a_msb);
    end
  end
`endif

endmodule
